// File: rtl/wallace_mac_accumulator_4.sv
// rtl/wallace_mac_accumulator_4.sv - 4x4 Wallace/CLA multiply-accumulate over N_TERMS products
// Multiplier helper and the two-stage accumulate pipeline with ACCUM/DONE result handshake.

module wallace_mul_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [7:0] pp0, pp1, pp2, pp3;
  logic [7:0] s1, c1, s2, c2;
  logic [6:0] m1, m2;
  logic [7:0] g, t;
  logic [3:0] cin_lo, cin_hi;
  logic       c4;

  function automatic logic [3:0] cla_cin(input logic [3:0] gg, input logic [3:0] pp,
                                         input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = gg[0] | (pp[0] & ci);
    c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
    c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & ci);
    return c;
  endfunction

  assign pp0 = {4'b0000, a & {4{b[0]}}};
  assign pp1 = {3'b000, a & {4{b[1]}}, 1'b0};
  assign pp2 = {2'b00, a & {4{b[2]}}, 2'b00};
  assign pp3 = {1'b0, a & {4{b[3]}}, 3'b000};

  // Two carry-save layers reduce four rows to two; no row reaches bit 7, so carries stop at bit 7.
  assign s1 = pp0 ^ pp1 ^ pp2;
  assign m1 = (pp0[6:0] & pp1[6:0]) | (pp0[6:0] & pp2[6:0]) | (pp1[6:0] & pp2[6:0]);
  assign c1 = {m1, 1'b0};
  assign s2 = s1 ^ c1 ^ pp3;
  assign m2 = (s1[6:0] & c1[6:0]) | (s1[6:0] & pp3[6:0]) | (c1[6:0] & pp3[6:0]);
  assign c2 = {m2, 1'b0};

  assign g = s2 & c2;
  assign t = s2 ^ c2;
  assign c4 = g[3] | (t[3] & g[2]) | (t[3] & t[2] & g[1]) | (t[3] & t[2] & t[1] & g[0]);

  always_comb begin
    cin_lo = cla_cin(g[3:0], t[3:0], 1'b0);
    cin_hi = cla_cin(g[7:4], t[7:4], c4);
    p = t ^ {cin_hi, cin_lo};
  end
endmodule

module wallace_mac_accumulator_4 #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);
  localparam int CW = $clog2(N_TERMS + 1);
  localparam logic [CW-1:0] N_MAX  = CW'(N_TERMS);
  localparam logic [CW-1:0] N_LAST = CW'(N_TERMS - 1);

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_in_q, cnt_in_d;
  logic [CW-1:0]    cnt_sum_q, cnt_sum_d;
  logic [7:0]       prod_q, prod_d;
  logic             prod_vld_q, prod_vld_d;
  logic [7:0]       mul_p;
  logic [ACC_W:0]   sum_ext;
  logic             in_fire;

  wallace_mul_4x4 u_mul (
    .a (a),
    .b (b),
    .p (mul_p)
  );

  assign in_ready  = (state_q == ACCUM) && (cnt_in_q < N_MAX);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;
  assign sum_ext   = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, prod_q};

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    cnt_in_d   = cnt_in_q;
    cnt_sum_d  = cnt_sum_q;
    prod_d     = prod_q;
    prod_vld_d = 1'b0;
    if (state_q == DONE) begin
      if (out_ready) begin
        state_d   = ACCUM;
        acc_d     = '0;
        ovf_d     = 1'b0;
        cnt_in_d  = '0;
        cnt_sum_d = '0;
      end
    end else begin
      if (in_fire) begin
        prod_d     = mul_p;
        prod_vld_d = 1'b1;
        cnt_in_d   = cnt_in_q + CW'(1);
      end
      // Stage 2: fold last cycle's product in; the carry out of the top bit is sticky.
      if (prod_vld_q) begin
        acc_d     = sum_ext[ACC_W-1:0];
        ovf_d     = ovf_q | sum_ext[ACC_W];
        cnt_sum_d = cnt_sum_q + CW'(1);
        if (cnt_sum_q == N_LAST) state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_in_q   <= '0;
      cnt_sum_q  <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      cnt_in_q   <= cnt_in_d;
      cnt_sum_q  <= cnt_sum_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
    end
  end
endmodule

// File: doc/wallace_mac_accumulator_4.md
WALLACE_MAC_ACCUMULATOR_4 -- requirements
Module: wallace_mac_accumulator_4

Interface
REQ-001 SHALL have parameter N_TERMS, default 4, meaning the number of products summed per result (legal range 2..16).
REQ-002 SHALL have parameter ACC_W, default 12, meaning the accumulator and result width (legal range 8..32).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning the operand pair is valid.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the block accepts an operand pair this cycle.
REQ-007 SHALL have port a, input, 4 bits, the unsigned multiplicand.
REQ-008 SHALL have port b, input, 4 bits, the unsigned multiplier.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning the result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit, meaning downstream accepts the result.
REQ-011 SHALL have port out_acc, output, ACC_W bits, the accumulated sum.
REQ-012 SHALL have port out_ovf, output, 1 bit, the sticky overflow flag for the current result.

Function
REQ-013 SHALL form each product by instantiating the team's 4-bit unsigned Wallace/CLA multiplier (8-bit product); no behavioural "*" operator.
REQ-014 SHALL treat a handshake as occurring on a rising edge where in_valid=1 and in_ready=1; operands are sampled only then.
REQ-015 SHALL register the product in an 8-bit product register plus a valid bit on the handshake edge (pipeline stage 1).
REQ-016 SHALL add the zero-extended product register to the accumulator on the following edge (stage 2) and increment the summed-term counter.
REQ-017 SHALL keep the accumulator modulo 2^ACC_W and set the sticky ovf bit on any carry out of bit ACC_W-1.
REQ-018 SHALL implement two states, ACCUM and DONE.
REQ-019 SHALL drive in_ready = (state==ACCUM) AND (accepted count < N_TERMS); back-to-back handshakes are allowed every cycle.
REQ-020 SHALL move from ACCUM to DONE on the edge that adds the N_TERMS-th product.
REQ-021 SHALL give a latency of 2 edges from the last handshake edge to out_valid=1.
REQ-022 SHALL assert out_valid=1 in DONE, with out_acc and out_ovf held stable until accepted.
REQ-023 SHALL, on an edge with out_valid=1 and out_ready=1, clear the accumulator, ovf and both counters, and return to ACCUM.
REQ-024 SHALL re-assert in_ready in the cycle after the result handshake; no operand is accepted in the same cycle as the result handshake.
REQ-025 SHALL ignore in_valid while in_ready=0; a, b and in_valid changes there have no effect.
REQ-026 SHALL ignore out_ready while out_valid=0.
REQ-027 SHALL drive out_valid=0 in ACCUM; out_acc there shows the running sum, which is not guaranteed to consumers.
REQ-028 SHALL tolerate in_valid gaps between terms; a partial sum is held indefinitely with no timeout.

Reset
REQ-029 SHALL, on rst=1 and independent of clk, force: state ACCUM, accumulator 0, ovf 0, both counters 0, product-valid 0.
REQ-030 SHALL drive outputs during and after reset as: in_ready=1 (combinational from state), out_valid=0, out_acc=0, out_ovf=0.
REQ-031 SHALL discard any in-flight product or partial sum on reset mid-operation; the first handshake after release starts a new N_TERMS group.

Verification
REQ-032 SHALL cover: N_TERMS=4, pairs (3,5),(15,15),(0,9),(7,2) back-to-back -> out_valid 2 edges after the 4th handshake, out_acc=254, out_ovf=0, in_ready=0 after the 4th handshake.
REQ-033 SHALL cover: ACC_W=8, N_TERMS=2, pairs (15,15),(15,15) -> out_acc=450 mod 256=194, out_ovf=1.
REQ-034 SHALL cover: result ready, out_ready held 0 for 5 cycles with in_valid=1 -> out_acc stable, in_ready=0, no operand consumed; out_ready=1 -> next cycle in_ready=1, accumulator restarts from 0.
REQ-035 SHALL cover: in_valid toggling 1,0,0,1,0,1,1 with pairs (1,1) -> out_acc=4 only after the 4th handshake.
REQ-036 SHALL cover: rst pulsed asynchronously (mid-cycle) after 2 of 4 handshakes -> outputs reset immediately; next 4 pairs of (2,3) -> out_acc=24.
REQ-037 SHALL cover: exhaustive sweep of all 256 (a,b) pairs as single-term groups (N_TERMS=2, second pair (0,0)) -> out_acc=a*b for each.
